// File: rtl/run_detect_pkg.sv
// run_detect_pkg: shared FSM state encoding and default threshold for run_detect_ctrl
package run_detect_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, DETECT = 2'b10} state_t;
  localparam int DEFAULT_THRESH = 3;
endpackage

// File: rtl/run_counter.sv
// run_counter: saturating up-counter with sync clear; ports clk/reset, clr, inc, limit (saturation value), cnt
module run_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt < limit) cnt <= cnt + W'(1);
endmodule

// File: rtl/run_detect_ctrl.sv
// run_detect_ctrl: programmable consecutive-ones detector; cfg_valid/cfg_thresh/cfg_ready load threshold in IDLE, start/stop arm, in is the serial bit, detect/busy/evt_count report
module run_detect_ctrl #(
  parameter int CNT_W = 4,
  parameter int EVT_W = 8,
  parameter int DEFAULT_THRESH = run_detect_pkg::DEFAULT_THRESH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_thresh,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  input  logic             in,
  output logic             detect,
  output logic             busy,
  output logic [EVT_W-1:0] evt_count
);
  import run_detect_pkg::*;
  state_t state, next;
  logic [CNT_W-1:0] thresh, run_cnt;
  logic armed, hit, arm_req;
  assign armed   = state == ARMED || state == DETECT;
  assign hit     = state == ARMED && !stop && in && run_cnt == thresh - CNT_W'(1);
  assign arm_req = state == IDLE && start && !stop;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = IDLE;
    case (state)
      IDLE:    next = arm_req ? ARMED : IDLE;
      ARMED:   next = stop ? IDLE : hit ? DETECT : ARMED;
      DETECT:  next = stop ? IDLE : in ? DETECT : ARMED;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) thresh <= CNT_W'(DEFAULT_THRESH);
    else if (state == IDLE && cfg_valid) thresh <= cfg_thresh == '0 ? CNT_W'(1) : cfg_thresh;
  run_counter #(.W(CNT_W)) u_run (
    .clk(clk), .reset(reset), .clr(!armed || stop || !in), .inc(in), .limit(thresh), .cnt(run_cnt)
  );
  run_counter #(.W(EVT_W)) u_evt (
    .clk(clk), .reset(reset), .clr(arm_req), .inc(hit), .limit({EVT_W{1'b1}}), .cnt(evt_count)
  );
  assign detect    = state == DETECT;
  assign busy      = state != IDLE;
  assign cfg_ready = state == IDLE;
endmodule

// File: tb/tb_run_detect_ctrl.sv
// tb_run_detect_ctrl: directed self-checking bench for run_detect_ctrl
module tb_run_detect_ctrl;
  logic clk = 0, reset = 1, cfg_valid = 0, start = 0, stop = 0, in = 0;
  logic [3:0] cfg_thresh = 0;
  logic cfg_ready, detect, busy, cfg_ready2, detect2, busy2;
  logic [7:0] evt_count;
  logic [1:0] evt_count2;
  int tests = 0, fails = 0;
  run_detect_ctrl dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_thresh(cfg_thresh), .cfg_ready(cfg_ready),
    .start(start), .stop(stop), .in(in), .detect(detect), .busy(busy), .evt_count(evt_count)
  );
  run_detect_ctrl #(.EVT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_thresh(cfg_thresh), .cfg_ready(cfg_ready2),
    .start(start), .stop(stop), .in(in), .detect(detect2), .busy(busy2), .evt_count(evt_count2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12;
    chk("rst_detect", detect, 0);
    chk("rst_busy", busy, 0);
    chk("rst_evt", evt_count, 0);
    chk("rst_ready", cfg_ready, 1);
    reset = 0;
    tick();
    start = 1; tick(); start = 0;
    chk("t1_busy", busy, 1);
    chk("t1_ready", cfg_ready, 0);
    in = 1; tick(); chk("t1_d1", detect, 0);
    tick(); chk("t1_d2", detect, 0);
    tick(); chk("t1_d3", detect, 1); chk("t1_evt3", evt_count, 1);
    tick(); chk("t1_d4", detect, 1);
    in = 0; tick(); chk("t1_d5", detect, 0); chk("t1_evt", evt_count, 1);
    stop = 1; tick(); stop = 0;
    chk("t1_stop_busy", busy, 0); chk("t1_hold_evt", evt_count, 1);
    cfg_valid = 1; cfg_thresh = 5; tick(); cfg_valid = 0;
    start = 1; tick(); start = 0;
    chk("t2_evt_clr", evt_count, 0);
    in = 1;
    for (int i = 0; i < 4; i++) begin tick(); chk("t2_run1", detect, 0); end
    in = 0; tick(); chk("t2_gap", detect, 0);
    in = 1;
    for (int i = 0; i < 4; i++) begin tick(); chk("t2_run2", detect, 0); end
    tick(); chk("t2_d5", detect, 1); chk("t2_evt", evt_count, 1);
    in = 0; tick(); chk("t2_fall", detect, 0);
    stop = 1; tick(); stop = 0;
    cfg_valid = 1; cfg_thresh = 0; start = 1; tick(); cfg_valid = 0; start = 0;
    chk("t3_busy", busy, 1);
    in = 1; tick(); chk("t3_d1", detect, 1); chk("t3_evt1", evt_count, 1);
    in = 0; tick(); chk("t3_d2", detect, 0);
    in = 1; tick(); chk("t3_d3", detect, 1); chk("t3_evt2", evt_count, 2);
    stop = 1; tick(); stop = 0;
    chk("t4_stop_det", detect, 0); chk("t4_stop_busy", busy, 0); chk("t4_stop_evt", evt_count, 2);
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    chk("t4_both_busy", busy, 0); chk("t4_both_ready", cfg_ready, 1);
    in = 0; start = 1; tick(); start = 0;
    cfg_valid = 1; cfg_thresh = 7; tick(); cfg_valid = 0;
    chk("t4_busy_ready", cfg_ready, 0);
    in = 1; tick(); chk("t4_thresh_kept", detect, 1); chk("t4_evt", evt_count, 1);
    for (int i = 0; i < 4; i++) begin
      in = 0; tick();
      in = 1; tick();
    end
    chk("t5_evt8", evt_count, 5);
    chk("t5_evt2_sat", evt_count2, 3);
    chk("t5_det2", detect2, 1);
    #2 reset = 1;
    #1;
    chk("t6_det", detect, 0); chk("t6_busy", busy, 0); chk("t6_evt", evt_count, 0);
    chk("t6_evt2", evt_count2, 0); chk("t6_ready", cfg_ready, 1);
    reset = 0;
    start = 1; in = 1; tick(); start = 0;
    tick(); chk("t6_r1", detect, 0);
    tick(); chk("t6_r2", detect, 0);
    tick(); chk("t6_r3", detect, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
